axi_err_slave: RTL and testbench
================================

AXI_ERR_SLAVE -- requirements
Module: axi_err_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the R data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, giving the awaddr/araddr width; address is accepted and ignored.
REQ-003 SHALL have parameter ID_WIDTH, default 8, giving the width of the AXI ID fields.
REQ-004 SHALL have parameter RESP, default 2'b11 (DECERR), giving the response code returned on every B and R beat.
REQ-005 SHALL have ports, one per line below: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axi_awid  in  ID_WIDTH  write ID.
- s_axi_awaddr  in  ADDR_WIDTH  ignored.
- s_axi_awlen  in  8  ignored; wlast terminates the burst.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wlast  in  1  final write beat.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake; wdata/wstrb not ported.
- s_axi_bid  out  ID_WIDTH  latched awid.
- s_axi_bresp  out  2  equals RESP.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_arid  in  ID_WIDTH  read ID.
- s_axi_araddr  in  ADDR_WIDTH  ignored.
- s_axi_arlen  in  8  burst length minus 1.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rid  out  ID_WIDTH  latched arid.
- s_axi_rdata  out  DATA_WIDTH  constant 0.
- s_axi_rresp  out  2  equals RESP.
- s_axi_rlast  out  1  final read beat.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.

Function
REQ-006 Write and read paths SHALL be independent FSMs running concurrently, with no shared state.
REQ-007 The write FSM SHALL have states WR_IDLE, WR_DATA and WR_RESP.
- awready = 1 only in WR_IDLE.
- wready = 1 only in WR_DATA.
- bvalid = 1 only in WR_RESP.
REQ-008 On awvalid&&awready, the write FSM SHALL latch awid into bid and enter WR_DATA; wready is high the next cycle.
REQ-009 In WR_DATA, the write FSM SHALL consume beats on wvalid&&wready and enter WR_RESP after the beat with wlast=1; bvalid is high the next cycle.
REQ-010 In WR_RESP, the write FSM SHALL hold bvalid, bid and bresp stable until bready, then return to WR_IDLE; awready is high the next cycle.
REQ-011 W beats presented in WR_IDLE SHALL stall (wready=0); a single-beat burst with wlast=1 SHALL complete in the first WR_DATA cycle.
REQ-012 The read FSM SHALL have states RD_IDLE and RD_DATA.
- arready = 1 only in RD_IDLE.
- rvalid = 1 only in RD_DATA.
REQ-013 On arvalid&&arready, the read FSM SHALL latch arid, load the 8-bit beat counter with arlen and enter RD_DATA; rvalid is high the next cycle.
REQ-014 In RD_DATA, rlast SHALL equal (counter==0), rdata SHALL be 0 and rresp SHALL be RESP.
REQ-015 On rvalid&&rready in RD_DATA, the read FSM SHALL return to RD_IDLE if counter==0, else decrement the counter.
REQ-016 The read burst SHALL return exactly arlen+1 beats; arlen=255 yields 256 beats, and the counter never wraps.
REQ-017 While rready=0, rvalid, rid, rlast and rresp SHALL remain stable.
REQ-018 Throughput SHALL be one transaction per channel at a time; no outstanding-transaction queueing.

Reset
REQ-019 While rst=1:
- both FSMs go to IDLE and the counter clears;
- awready, wready, bvalid, arready, rvalid and rlast are 0;
- bid and rid are 0.
REQ-020 awready and arready SHALL be 1 in the first cycle after rst deasserts.
REQ-021 Reset asserted mid-burst SHALL abandon the transaction with no B or R beat issued afterward.

Verification
REQ-022 AW id=0x5A, then 4 W beats with wlast on beat 4, bready=1 -> exactly one B with bid=0x5A, bresp=2'b11, one cycle after the wlast handshake.
REQ-023 AR id=0x3C, arlen=0, rready=1 -> one R beat: rid=0x3C, rdata=0, rresp=2'b11, rlast=1; arready high again the next cycle.
REQ-024 AR arlen=255 with rready toggling randomly -> 256 R beats, rlast only on beat 256, outputs stable while stalled.
REQ-025 Concurrent AW/W and AR bursts with bready=0 for 10 cycles -> R burst completes unaffected, bvalid held 10 cycles, awready=0 throughout.
REQ-026 rst pulsed during R beat 3 of 8 -> rvalid=0 from the next cycle and arready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/axi_err_slave.sv
// axi_err_slave: AXI sink answering every burst with RESP; ports clk/rst plus AXI AW/W/B (write) and AR/R (read) channels
module axi_err_slave #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter int         ID_WIDTH   = 8,
  parameter logic [1:0] RESP       = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_e;
  wr_e wr_q, wr_d;
  rd_e rd_q, rd_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [7:0] cnt_q, cnt_d;
  logic unused;
  assign unused = ^{s_axi_awaddr, s_axi_awlen, s_axi_araddr};
  always_comb begin
    wr_d = wr_q;
    bid_d = bid_q;
    if (wr_q == WR_IDLE && s_axi_awvalid) begin
      wr_d = WR_DATA;
      bid_d = s_axi_awid;
    end
    if (wr_q == WR_DATA && s_axi_wvalid && s_axi_wlast) wr_d = WR_RESP;
    if (wr_q == WR_RESP && s_axi_bready) wr_d = WR_IDLE;
  end
  always_comb begin
    rd_d = rd_q;
    rid_d = rid_q;
    cnt_d = cnt_q;
    if (rd_q == RD_IDLE && s_axi_arvalid) begin
      rd_d = RD_DATA;
      rid_d = s_axi_arid;
      cnt_d = s_axi_arlen;
    end
    if (rd_q == RD_DATA && s_axi_rready) begin
      if (cnt_q == 8'd0) rd_d = RD_IDLE;
      else cnt_d = cnt_q - 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
      bid_q <= '0;
      rid_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      bid_q <= bid_d;
      rid_q <= rid_d;
      cnt_q <= cnt_d;
    end
  end
  // Outputs are masked by rst so they read as idle for the whole reset pulse, not only after its first edge.
  assign s_axi_awready = !rst && wr_q == WR_IDLE;
  assign s_axi_wready  = !rst && wr_q == WR_DATA;
  assign s_axi_bvalid  = !rst && wr_q == WR_RESP;
  assign s_axi_bid     = rst ? '0 : bid_q;
  assign s_axi_bresp   = RESP;
  assign s_axi_arready = !rst && rd_q == RD_IDLE;
  assign s_axi_rvalid  = !rst && rd_q == RD_DATA;
  assign s_axi_rlast   = !rst && rd_q == RD_DATA && cnt_q == 8'd0;
  assign s_axi_rid     = rst ? '0 : rid_q;
  assign s_axi_rdata   = '0;
  assign s_axi_rresp   = RESP;
endmodule

// File: tb/tb_axi_err_slave.sv
// tb_axi_err_slave: directed vector table plus multi-cycle sequences for axi_err_slave
module tb_axi_err_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [7:0] s_axi_awid, s_axi_awlen, s_axi_bid, s_axi_arid, s_axi_arlen, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_rdata;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  axi_err_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );
  typedef struct packed {
    logic rst, awv;
    logic [7:0] awid;
    logic wv, wl, br, arv;
    logic [7:0] arid, arlen;
    logic rr;
    logic awr, wr, bv;
    logic [7:0] bid;
    logic arr, rv;
    logic [7:0] rid;
    logic rl;
  } vec_t;
  vec_t v [19];
  int passed = 0, total = 0, beats, bad, bcyc;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[1]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    v[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    v[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h3C, 1'b1};
    v[11] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h3C, 1'b0};
    v[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h3C, 1'b0};
    v[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h3C, 1'b0};
    v[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h3C, 1'b0};
    v[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h3C, 1'b0};
    v[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'h77, 1'b0};
    v[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = 32'hDEAD_0000; s_axi_awlen = 8'd3; s_axi_awvalid = 1'b0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = 32'hBEEF_0000; s_axi_arlen = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    step();
    step();
    for (int i = 0; i < 19; i++) begin
      rst = v[i].rst; s_axi_awvalid = v[i].awv; s_axi_awid = v[i].awid;
      s_axi_wvalid = v[i].wv; s_axi_wlast = v[i].wl; s_axi_bready = v[i].br;
      s_axi_arvalid = v[i].arv; s_axi_arid = v[i].arid; s_axi_arlen = v[i].arlen; s_axi_rready = v[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rlast,
           s_axi_rdata == 32'd0, s_axi_bresp, s_axi_rresp},
          {v[i].awr, v[i].wr, v[i].bv, v[i].bid, v[i].arr, v[i].rv, v[i].rid, v[i].rl, 1'b1, 2'b11, 2'b11});
      step();
    end
    s_axi_arvalid = 1'b1; s_axi_arid = 8'h42; s_axi_arlen = 8'hFF; s_axi_rready = 1'b0;
    @(negedge clk);
    chk("rd255_ar", {63'd0, s_axi_arready}, 64'd1);
    step();
    s_axi_arvalid = 1'b0;
    beats = 0; bad = 0;
    for (int c = 0; c < 4000 && beats < 256; c++) begin
      s_axi_rready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!(s_axi_rvalid && s_axi_rid == 8'h42 && s_axi_rlast == (beats == 255) && s_axi_rdata == 32'd0 && s_axi_rresp == 2'b11)) bad++;
      if (s_axi_rvalid && s_axi_rready) beats++;
      step();
    end
    s_axi_rready = 1'b0;
    chk("rd255_beats", 64'(beats), 64'd256);
    chk("rd255_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    chk("rd255_done", {s_axi_rvalid, s_axi_arready}, 64'b01);
    step();
    s_axi_awvalid = 1'b1; s_axi_awid = 8'h21; s_axi_arvalid = 1'b1; s_axi_arid = 8'h65; s_axi_arlen = 8'd7;
    s_axi_rready = 1'b1; s_axi_bready = 1'b0;
    beats = 0; bad = 0; bcyc = 0;
    for (int c = 0; c < 13; c++) begin
      s_axi_wvalid = (c == 1 || c == 2);
      s_axi_wlast = (c == 2);
      @(negedge clk);
      if (c == 0 && !(s_axi_awready && s_axi_arready)) bad++;
      if (c >= 1 && c <= 8 && !(s_axi_rvalid && s_axi_rid == 8'h65 && s_axi_rlast == (beats == 7))) bad++;
      if (c >= 9 && s_axi_rvalid) bad++;
      if (c >= 1 && s_axi_awready) bad++;
      if (c >= 1 && c <= 2 && !s_axi_wready) bad++;
      if (s_axi_bvalid) begin
        bcyc++;
        if (s_axi_bid != 8'h21 || s_axi_bresp != 2'b11) bad++;
      end
      if (s_axi_rvalid && s_axi_rready) beats++;
      step();
      s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    end
    chk("conc_rbeats", 64'(beats), 64'd8);
    chk("conc_bvalid_cycles", 64'(bcyc), 64'd10);
    chk("conc_bad_cycles", 64'(bad), 64'd0);
    s_axi_bready = 1'b1;
    @(negedge clk);
    chk("conc_b_accept", {s_axi_bvalid, s_axi_awready, s_axi_bid}, {2'b10, 8'h21});
    step();
    s_axi_bready = 1'b0;
    @(negedge clk);
    chk("conc_b_done", {s_axi_bvalid, s_axi_awready}, 64'b01);
    step();
    s_axi_arvalid = 1'b1; s_axi_arid = 8'h0F; s_axi_arlen = 8'd7; s_axi_rready = 1'b1;
    @(negedge clk);
    chk("rst_ar", {63'd0, s_axi_arready}, 64'd1);
    step();
    s_axi_arvalid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (!s_axi_rvalid || s_axi_rlast) bad++;
      step();
    end
    @(negedge clk);
    chk("rst_beat3", {bad[7:0], s_axi_rvalid, s_axi_rlast, s_axi_rid}, {8'd0, 2'b10, 8'h0F});
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after", {s_axi_rvalid, s_axi_arready, s_axi_awready, s_axi_bvalid, s_axi_rid}, {4'b0110, 8'h00});
    step();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (s_axi_rvalid || s_axi_bvalid || !s_axi_arready) bad++;
      step();
    end
    chk("rst_no_beats", 64'(bad), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
